// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetrimino display path.
package tetris_pkg;

  localparam int COORD_WIDTH = 5;
  localparam int BOARD_MAX   = 7;

  typedef logic [7:0][7:0]               matrix_t;
  typedef logic signed [COORD_WIDTH-1:0] coord_t;

  typedef enum logic {
    IDLE,
    PLACE
  } render_state_t;

endpackage

// File: rtl/tetrimino_cell_mask.sv
// Combinational decode of one signed (x,y) cell into a one-hot 8x8 mask
// plus an out-of-bounds bit; the mask is all-zero for out-of-bounds cells.
module tetrimino_cell_mask
  import tetris_pkg::*;
#(
  parameter int COORD_W = COORD_WIDTH
) (
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  output matrix_t                   mask,
  output logic                      oob
);

  localparam logic signed [COORD_W-1:0] MAX_C = COORD_W'(BOARD_MAX);

  // Full-width signed check so e.g. x=8 or x=-8 never aliases onto the board.
  assign oob = x[COORD_W-1] | (x > MAX_C) | y[COORD_W-1] | (y > MAX_C);

  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    for (genvar gj = 0; gj < 8; gj++) begin : g_col
      assign mask[gi][gj] = ~oob & (x[2:0] == 3'(gj)) & (y[2:0] == 3'(gi));
    end
  end

endmodule

// File: rtl/tetrimino_renderer.sv
// Rasterises NUM_CELLS signed cells into an 8x8 matrix, one cell per cycle,
// flagging collision/out-of-bounds/overlap. Option: RENDER_COMMIT_ON_OK_EN.
module tetrimino_renderer
  import tetris_pkg::*;
#(
  parameter int COORD_W   = COORD_WIDTH,
  parameter int NUM_CELLS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CELLS-1:0][COORD_W-1:0] cellX,
  input  logic [NUM_CELLS-1:0][COORD_W-1:0] cellY,
  input  matrix_t                           fixedMatrixIn,
  output matrix_t                           matrixOut,
  output logic                              busy,
  output logic                              done,
  output logic                              collision,
  output logic                              outOfBounds,
  output logic                              overlap,
  output logic                              ok
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  render_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_CELLS-1:0][COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  matrix_t fixed_q, fixed_d, work_q, work_d, mat_q, mat_d;
  logic done_q, done_d, col_q, col_d, oob_q, oob_d, ovl_q, ovl_d, ok_q, ok_d;

  logic signed [COORD_W-1:0] cur_x, cur_y;
  matrix_t cell_mask;
  logic    cell_oob;
  logic    hit_work, hit_fixed;

  assign cur_x = $signed(cx_q[idx_q]);
  assign cur_y = $signed(cy_q[idx_q]);

  tetrimino_cell_mask #(
    .COORD_W(COORD_W)
  ) u_cell_mask (
    .x   (cur_x),
    .y   (cur_y),
    .mask(cell_mask),
    .oob (cell_oob)
  );

  assign hit_work  = |(cell_mask & work_q);
  assign hit_fixed = |(cell_mask & fixed_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fixed_d = fixed_q;
    work_d  = work_q;
    mat_d   = mat_q;
    done_d  = 1'b0;
    col_d   = col_q;
    oob_d   = oob_q;
    ovl_d   = ovl_q;
    ok_d    = ok_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cx_d    = cellX;
          cy_d    = cellY;
          fixed_d = fixedMatrixIn;
          work_d  = '0;
          col_d   = 1'b0;
          oob_d   = 1'b0;
          ovl_d   = 1'b0;
          idx_d   = '0;
          state_d = PLACE;
        end
      end
      PLACE: begin
        // Overlap takes priority over collision; both still draw the cell.
        if (cell_oob)       oob_d = 1'b1;
        else if (hit_work)  ovl_d = 1'b1;
        else if (hit_fixed) col_d = 1'b1;
        work_d = work_q | cell_mask;

        if (idx_q == LAST_IDX) begin
          ok_d    = ~(col_d | oob_d | ovl_d);
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef RENDER_COMMIT_ON_OK_EN
          if (ok_d) mat_d = work_d;
`else
          mat_d = work_d;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      fixed_q <= '0;
      work_q  <= '0;
      mat_q   <= '0;
      done_q  <= 1'b0;
      col_q   <= 1'b0;
      oob_q   <= 1'b0;
      ovl_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      fixed_q <= fixed_d;
      work_q  <= work_d;
      mat_q   <= mat_d;
      done_q  <= done_d;
      col_q   <= col_d;
      oob_q   <= oob_d;
      ovl_q   <= ovl_d;
      ok_q    <= ok_d;
    end
  end

  assign matrixOut   = mat_q;
  assign busy        = (state_q == PLACE);
  assign done        = done_q;
  assign collision   = col_q;
  assign outOfBounds = oob_q;
  assign overlap     = ovl_q;
  assign ok          = ok_q;

endmodule
